// File: rtl/sram_like_responder_if.sv
// sram_like_responder_if: sram-like request/response bus between a CPU-side initiator and a memory responder.
interface sram_like_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        stall;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  modport master (output req, wr, size, addr, wstrb, wdata, stall, input addr_ok, data_ok, rdata);
  modport slave (input req, wr, size, addr, wstrb, wdata, stall, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_responder.sv
// sram_like_responder: word-addressed RAM behind an sram-like bus; in-order responses after a fixed minimum latency.
module sram_like_responder #(
  parameter int AW = 10,
  parameter int LATENCY = 2,
  parameter int OUTSTANDING = 4
) (
  input logic clk,
  input logic resetn,
  sram_like_responder_if.slave bus
);
  localparam int PW = $clog2(OUTSTANDING);
  localparam logic [3:0] LAT = 4'(LATENCY);
  localparam logic [3:0] THR = 4'(LATENCY - 1);
  localparam logic [PW:0] DEPTH = (PW + 1)'(OUTSTANDING);
  logic [31:0] mem_q [2**AW];
  logic [31:0] data_q [OUTSTANDING];
  logic [31:0] data_d [OUTSTANDING];
  logic [3:0] age_q [OUTSTANDING];
  logic [3:0] age_d [OUTSTANDING];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0] count_q, count_d;
  logic [AW-1:0] widx;
  logic push, pop;
  logic unused_bits;
  assign widx = bus.addr[AW+1:2];
  assign unused_bits = ^{bus.size, bus.addr[31:AW+2], bus.addr[1:0]};
  always_comb begin
    push = resetn & bus.req & ~bus.stall & (count_q < DEPTH);
    pop = (count_q != '0) & (age_q[head_q] >= THR);
    bus.addr_ok = push;
    bus.data_ok = pop;
    bus.rdata = pop ? data_q[head_q] : '0;
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(push);
    count_d = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
    for (int i = 0; i < OUTSTANDING; i++) begin
      age_d[i] = (age_q[i] == LAT) ? age_q[i] : age_q[i] + 4'd1;
      data_d[i] = data_q[i];
    end
    if (push) begin
      age_d[tail_q] = '0;
      data_d[tail_q] = bus.wr ? '0 : mem_q[widx];
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      age_q <= '{default: '0};
      data_q <= '{default: '0};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      age_q <= age_d;
      data_q <= data_d;
    end
  end
  // RAM has no reset so its contents survive a resetn pulse
  always_ff @(posedge clk) begin
    if (push & bus.wr)
      for (int b = 0; b < 4; b++)
        if (bus.wstrb[b]) mem_q[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: three responders (LATENCY 2, 1, 6) checked against a queue-based scoreboard and RAM model.
module tb_sram_like_responder;
  typedef struct {logic [31:0] d; int c;} exp_t;
  logic clk = 0, resetn = 1;
  logic [2:0] req_v = '0;
  logic [2:0] addr_ok_v, data_ok_v;
  logic wr = 0, stall = 0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] wstrb = '0;
  logic [31:0] rdata_v [3];
  logic [31:0] last_v [3];
  int lat_v [3];
  int lat_e [3] = '{2, 1, 6};
  logic [31:0] mem_m [3][1024];
  exp_t q [3][$];
  int cyc = 0, vec = 0, miss = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : dut
    sram_like_responder_if b ();
    assign b.req = req_v[g];
    assign b.wr = wr;
    assign b.size = 2'd2;
    assign b.addr = addr;
    assign b.wstrb = wstrb;
    assign b.wdata = wdata;
    assign b.stall = stall;
    assign addr_ok_v[g] = b.addr_ok;
    assign data_ok_v[g] = b.data_ok;
    assign rdata_v[g] = b.rdata;
    sram_like_responder #(.AW(10), .LATENCY(g == 0 ? 2 : g == 1 ? 1 : 6), .OUTSTANDING(4)) u (
      .clk(clk), .resetn(resetn), .bus(b.slave));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Scoreboard: push on addr_ok, pop and compare on data_ok, per instance.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (!resetn) q[g].delete();
        else begin
          if (data_ok_v[g]) begin
            vec++;
            if (q[g].size() == 0) begin
              miss++;
              $display("FAIL dut%0d_spurious_data_ok: data_ok=1 rdata=%h, required no response", g, rdata_v[g]);
            end else begin
              e = q[g].pop_front();
              last_v[g] = rdata_v[g];
              lat_v[g] = cyc - e.c;
              if (rdata_v[g] !== e.d || lat_v[g] != lat_e[g]) begin
                miss++;
                $display("FAIL dut%0d_response: rdata=%h latency=%0d, required rdata=%h latency=%0d",
                         g, rdata_v[g], lat_v[g], e.d, lat_e[g]);
              end
            end
          end
          if (addr_ok_v[g]) begin
            e.d = wr ? '0 : mem_m[g][addr[11:2]];
            e.c = cyc;
            q[g].push_back(e);
            if (wr)
              for (int k = 0; k < 4; k++)
                if (wstrb[k]) mem_m[g][addr[11:2]][8*k +: 8] = wdata[8*k +: 8];
          end
        end
      end
    end
  endtask
  task automatic issue(input logic [2:0] m, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    logic [2:0] acc;
    wr = w; addr = a; wstrb = s; wdata = d; req_v = m;
    for (int k = 0; k < 30 && req_v != 0; k++) begin
      @(negedge clk);
      acc = addr_ok_v & req_v;
      tick();
      req_v &= ~acc;
    end
    vec++;
    if (req_v !== 3'b000) begin
      miss++;
      $display("FAIL issue_timeout: pending=%b, required 000", req_v);
      req_v = '0;
    end
  endtask
  task automatic drain();
    for (int k = 0; k < 40 && (q[0].size() + q[1].size() + q[2].size()) != 0; k++) tick();
    vec++;
    if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
      miss++;
      $display("FAIL drain_timeout: outstanding=%0d/%0d/%0d, required 0", q[0].size(), q[1].size(), q[2].size());
    end
    tick();
    tick();
  endtask
  task automatic test_reset();
    #1 resetn = 0;
    req_v = '1; wr = 0; addr = 32'h10;
    repeat (2) tick();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      vec++;
      if ({addr_ok_v[g], data_ok_v[g], rdata_v[g]} !== 34'b0) begin
        miss++;
        $display("FAIL dut%0d_reset_outputs: addr_ok=%b data_ok=%b rdata=%h, required 0 0 0",
                 g, addr_ok_v[g], data_ok_v[g], rdata_v[g]);
      end
    end
    req_v = '0;
    tick();
    resetn = 1;
    tick();
  endtask
  task automatic test_write_read();
    wr = 1; addr = 32'h10; wstrb = 4'hF; wdata = 32'hDEADBEEF; req_v = '1;
    @(negedge clk);
    vec++;
    if (addr_ok_v !== 3'b111) begin
      miss++;
      $display("FAIL write_addr_ok: addr_ok=%b, required 111", addr_ok_v);
    end
    tick();
    wr = 0;
    @(negedge clk);
    vec++;
    if (addr_ok_v !== 3'b111) begin
      miss++;
      $display("FAIL read_addr_ok: addr_ok=%b, required 111", addr_ok_v);
    end
    tick();
    req_v = '0;
    drain();
    for (int g = 0; g < 3; g++) begin
      vec++;
      if (last_v[g] !== 32'hDEADBEEF) begin
        miss++;
        $display("FAIL dut%0d_word_read: rdata=%h, required deadbeef", g, last_v[g]);
      end
    end
  endtask
  task automatic test_byte_write();
    issue(3'b111, 1, 32'h10, 4'h2, 32'h0000AB00);
    issue(3'b111, 0, 32'h10, 4'hF, 32'h0);
    drain();
    for (int g = 0; g < 3; g++) begin
      vec++;
      if (last_v[g] !== 32'hDEADABEF) begin
        miss++;
        $display("FAIL dut%0d_byte_merge: rdata=%h, required deadabef", g, last_v[g]);
      end
    end
  endtask
  task automatic test_stall();
    wr = 0; addr = 32'h10; stall = 1; req_v = '1;
    repeat (3) begin
      @(negedge clk);
      vec++;
      if ({addr_ok_v, data_ok_v} !== 6'b0) begin
        miss++;
        $display("FAIL stall_hold: addr_ok=%b data_ok=%b, required 000 000", addr_ok_v, data_ok_v);
      end
      tick();
    end
    stall = 0;
    @(negedge clk);
    vec++;
    if (addr_ok_v !== 3'b111) begin
      miss++;
      $display("FAIL stall_release: addr_ok=%b, required 111", addr_ok_v);
    end
    tick();
    req_v = '0;
    drain();
    for (int g = 0; g < 3; g++) begin
      vec++;
      if (lat_v[g] !== lat_e[g]) begin
        miss++;
        $display("FAIL dut%0d_stall_latency: latency=%0d, required %0d", g, lat_v[g], lat_e[g]);
      end
    end
  endtask
  task automatic test_back_to_back();
    int blk;
    logic dok;
    for (int k = 0; k < 5; k++) issue(3'b101, 1, 32'h200 + 32'(4 * k), 4'hF, 32'hA5A50000 + 32'(k));
    drain();
    wr = 0; req_v = 3'b001;
    for (int k = 0; k < 5; k++) begin
      addr = 32'h200 + 32'(4 * k);
      @(negedge clk);
      vec++;
      if (addr_ok_v[0] !== 1'b1) begin
        miss++;
        $display("FAIL b2b_lat2_accept%0d: addr_ok=%b, required 1", k, addr_ok_v[0]);
      end
      tick();
    end
    req_v = '0;
    drain();
    req_v = 3'b100;
    for (int k = 0; k < 4; k++) begin
      addr = 32'h200 + 32'(4 * k);
      @(negedge clk);
      vec++;
      if (addr_ok_v[2] !== 1'b1) begin
        miss++;
        $display("FAIL b2b_lat6_accept%0d: addr_ok=%b, required 1", k, addr_ok_v[2]);
      end
      tick();
    end
    addr = 32'h210;
    blk = 0;
    dok = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (addr_ok_v[2]) break;
      blk++;
      dok = data_ok_v[2];
      tick();
    end
    tick();
    req_v = '0;
    vec++;
    if (blk !== 3 || dok !== 1'b1) begin
      miss++;
      $display("FAIL b2b_full_block: blocked=%0d data_ok_before=%b, required 3 and 1", blk, dok);
    end
    drain();
    vec++;
    if (last_v[2] !== 32'hA5A50004) begin
      miss++;
      $display("FAIL b2b_last_order: rdata=%h, required a5a50004", last_v[2]);
    end
  endtask
  task automatic test_reset_mid();
    wr = 0; req_v = 3'b100;
    for (int k = 0; k < 2; k++) begin
      addr = 32'h200 + 32'(4 * k);
      @(negedge clk);
      vec++;
      if (addr_ok_v[2] !== 1'b1) begin
        miss++;
        $display("FAIL pre_reset_accept%0d: addr_ok=%b, required 1", k, addr_ok_v[2]);
      end
      tick();
    end
    req_v = '0;
    resetn = 0;
    tick();
    resetn = 1;
    repeat (10) begin
      @(negedge clk);
      vec++;
      if (data_ok_v !== 3'b000) begin
        miss++;
        $display("FAIL post_reset_silence: data_ok=%b, required 000", data_ok_v);
      end
      tick();
    end
    issue(3'b111, 0, 32'h10, 4'hF, 32'h0);
    drain();
    for (int g = 0; g < 3; g++) begin
      vec++;
      if (last_v[g] !== 32'hDEADABEF) begin
        miss++;
        $display("FAIL dut%0d_ram_retained: rdata=%h, required deadabef", g, last_v[g]);
      end
    end
  endtask
  task automatic test_alias();
    issue(3'b111, 1, 32'h1010, 4'hF, 32'h12345678);
    issue(3'b111, 0, 32'h0010, 4'hF, 32'h0);
    drain();
    for (int g = 0; g < 3; g++) begin
      vec++;
      if (last_v[g] !== 32'h12345678) begin
        miss++;
        $display("FAIL dut%0d_alias: rdata=%h, required 12345678", g, last_v[g]);
      end
    end
    vec++;
    if (lat_v[1] !== 1) begin
      miss++;
      $display("FAIL lat1_latency: latency=%0d, required 1", lat_v[1]);
    end
  endtask
  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_write_read();
    test_byte_write();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_alias();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
